// File: rtl/ex_stage.sv
// ex_stage: LoongArch EX stage with ALU, restoring divider, ALE check, data SRAM request.
// Ports: ID handshake + payload in, MEM handshake + payload out, data SRAM request out.

module alu (
   input  logic [11:0] alu_op,
   input  logic [31:0] alu_src1,
   input  logic [31:0] alu_src2,
   output logic [31:0] alu_result
);
   logic [31:0] add_r;
   logic [31:0] sub_r;
   logic [31:0] slt_r;
   logic [31:0] sltu_r;
   logic [31:0] and_r;
   logic [31:0] nor_r;
   logic [31:0] or_r;
   logic [31:0] xor_r;
   logic [31:0] sll_r;
   logic [31:0] srl_r;
   logic [31:0] sra_r;
   logic [31:0] lui_r;

   assign add_r  = alu_src1 + alu_src2;
   assign sub_r  = alu_src1 - alu_src2;
   assign slt_r  = {31'b0, $signed(alu_src1) < $signed(alu_src2)};
   assign sltu_r = {31'b0, alu_src1 < alu_src2};
   assign and_r  = alu_src1 & alu_src2;
   assign nor_r  = ~(alu_src1 | alu_src2);
   assign or_r   = alu_src1 | alu_src2;
   assign xor_r  = alu_src1 ^ alu_src2;
   assign sll_r  = alu_src1 << alu_src2[4:0];
   assign srl_r  = alu_src1 >> alu_src2[4:0];
   assign sra_r  = 32'($signed(alu_src1) >>> alu_src2[4:0]);
   assign lui_r  = alu_src2;

   // One-hot op: AND-OR mux so an all-zero op yields 0.
   assign alu_result =
        ({32{alu_op[0]}}  & add_r)
      | ({32{alu_op[1]}}  & sub_r)
      | ({32{alu_op[2]}}  & slt_r)
      | ({32{alu_op[3]}}  & sltu_r)
      | ({32{alu_op[4]}}  & and_r)
      | ({32{alu_op[5]}}  & nor_r)
      | ({32{alu_op[6]}}  & or_r)
      | ({32{alu_op[7]}}  & xor_r)
      | ({32{alu_op[8]}}  & sll_r)
      | ({32{alu_op[9]}}  & srl_r)
      | ({32{alu_op[10]}} & sra_r)
      | ({32{alu_op[11]}} & lui_r);
endmodule

module ex_stage #(
   parameter int DIV_ITERS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ds_to_es_valid,
   output logic        es_allowin,
   input  logic [31:0] ds_pc,
   input  logic [11:0] ds_alu_op,
   input  logic [31:0] ds_alu_src1,
   input  logic [31:0] ds_alu_src2,
   input  logic [3:0]  ds_div_op,
   input  logic [4:0]  ds_ld_inst,
   input  logic [2:0]  ds_st_op,
   input  logic [31:0] ds_rkd_value,
   input  logic        ds_rf_we,
   input  logic [4:0]  ds_rf_waddr,
   input  logic        ds_csr_re,
   input  logic [85:0] ds_ex_zip,
   input  logic        ms_allowin,
   input  logic        ms_ex,
   input  logic        wb_ex,
   output logic        es_to_ms_valid,
   output logic [31:0] es_pc,
   output logic [31:0] es_result,
   output logic [31:0] es_alu_result,
   output logic        es_res_from_mem,
   output logic        es_rf_we,
   output logic [4:0]  es_rf_waddr,
   output logic [4:0]  es_ld_inst,
   output logic        es_csr_re,
   output logic [85:0] es_ex_zip,
   output logic        data_sram_en,
   output logic [3:0]  data_sram_we,
   output logic [31:0] data_sram_addr,
   output logic [31:0] data_sram_wdata
);
   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } div_st_e;

   localparam logic [4:0] LAST = 5'(DIV_ITERS - 1);

   logic        es_valid_q, es_valid_d;
   logic [31:0] pc_q, pc_d;
   logic [11:0] alu_op_q, alu_op_d;
   logic [31:0] src1_q, src1_d;
   logic [31:0] src2_q, src2_d;
   logic [3:0]  div_op_q, div_op_d;
   logic [4:0]  ld_q, ld_d;
   logic [2:0]  store_q, store_d;
   logic [31:0] rkd_q, rkd_d;
   logic        rf_we_q, rf_we_d;
   logic [4:0]  waddr_q, waddr_d;
   logic        csr_re_q, csr_re_d;
   logic [85:0] zip_q, zip_d;

   div_st_e     div_st_q, div_st_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dsor_q, dsor_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;

   logic [31:0] alu_res;
   logic [31:0] addr;
   logic        ale;
   logic        es_ex;
   logic        is_div;
   logic        is_load;
   logic        is_store;
   logic        signed_op;
   logic        s1_neg;
   logic        s2_neg;
   logic        ready_go;
   logic        hs_in;
   logic [32:0] rem_sh;
   logic        take;
   logic [31:0] q_out;
   logic [31:0] r_out;
   logic [3:0]  we_mask;
   logic [31:0] wdata;

   alu u_alu (
      .alu_op     (alu_op_q),
      .alu_src1   (src1_q),
      .alu_src2   (src2_q),
      .alu_result (alu_res)
   );

   assign addr     = alu_res;
   assign is_div   = |div_op_q;
   assign is_load  = |ld_q;
   assign is_store = |store_q;

   assign ale = ((ld_q[2] | ld_q[1] | store_q[1]) & addr[0])
              | ((ld_q[0] | store_q[0]) & (|addr[1:0]));

   assign es_ex_zip = {zip_q[85:1], zip_q[0] | ale};
   assign es_ex     = |es_ex_zip[6:0];

   // A faulting div never starts the divider, so it must not wait on it.
   assign ready_go = !is_div || es_ex || (div_st_q == DONE);

   assign es_allowin     = !es_valid_q || (ready_go && ms_allowin) || wb_ex;
   assign es_to_ms_valid = es_valid_q && ready_go && !wb_ex;
   assign hs_in          = ds_to_es_valid && es_allowin;

   always_comb begin
      es_valid_d = es_valid_q;
      pc_d       = pc_q;
      alu_op_d   = alu_op_q;
      src1_d     = src1_q;
      src2_d     = src2_q;
      div_op_d   = div_op_q;
      ld_d       = ld_q;
      store_d    = store_q;
      rkd_d      = rkd_q;
      rf_we_d    = rf_we_q;
      waddr_d    = waddr_q;
      csr_re_d   = csr_re_q;
      zip_d      = zip_q;
      if (hs_in) begin
         pc_d     = ds_pc;
         alu_op_d = ds_alu_op;
         src1_d   = ds_alu_src1;
         src2_d   = ds_alu_src2;
         div_op_d = ds_div_op;
         ld_d     = ds_ld_inst;
         store_d  = ds_st_op;
         rkd_d    = ds_rkd_value;
         rf_we_d  = ds_rf_we;
         waddr_d  = ds_rf_waddr;
         csr_re_d = ds_csr_re;
         zip_d    = ds_ex_zip;
      end
      if (wb_ex) begin
         es_valid_d = 1'b0;
      end else if (es_allowin) begin
         es_valid_d = ds_to_es_valid;
      end
   end

   assign signed_op = div_op_q[3] | div_op_q[2];
   assign s1_neg    = signed_op & src1_q[31];
   assign s2_neg    = signed_op & src2_q[31];

   // Restoring step: shift next dividend bit into the partial remainder.
   assign rem_sh = {rem_q, quo_q[31]};
   assign take   = rem_sh >= {1'b0, dsor_q};

   always_comb begin
      div_st_d = div_st_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dsor_d   = dsor_q;
      cnt_d    = cnt_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      unique case (div_st_q)
         IDLE: begin
            if (es_valid_q && is_div && !es_ex) begin
               div_st_d = BUSY;
               rem_d    = '0;
               quo_d    = s1_neg ? -src1_q : src1_q;
               dsor_d   = s2_neg ? -src2_q : src2_q;
               cnt_d    = '0;
               qneg_d   = s1_neg ^ s2_neg;
               rneg_d   = s1_neg;
            end
         end
         BUSY: begin
            if (take) begin
               rem_d = 32'(rem_sh - {1'b0, dsor_q});
            end else begin
               rem_d = rem_sh[31:0];
            end
            quo_d = {quo_q[30:0], take};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == LAST) begin
               div_st_d = DONE;
            end
         end
         DONE: begin
            if (es_to_ms_valid && ms_allowin) begin
               div_st_d = IDLE;
            end
         end
         default: div_st_d = IDLE;
      endcase
      if (wb_ex) begin
         div_st_d = IDLE;
      end
   end

   // Zero divisor: all-ones quotient, raw dividend as remainder.
   always_comb begin
      q_out = qneg_q ? -quo_q : quo_q;
      r_out = rneg_q ? -rem_q : rem_q;
      if (dsor_q == '0) begin
         q_out = '1;
         r_out = src1_q;
      end
   end

   always_comb begin
      es_result = alu_res;
      if (div_op_q[3] | div_op_q[1]) begin
         es_result = q_out;
      end else if (div_op_q[2] | div_op_q[0]) begin
         es_result = r_out;
      end
   end

   always_comb begin
      we_mask = 4'b0000;
      wdata   = rkd_q;
      unique case (1'b1)
         store_q[2]: begin
            we_mask = 4'b0001 << addr[1:0];
            wdata   = {4{rkd_q[7:0]}};
         end
         store_q[1]: begin
            we_mask = 4'b0011 << {addr[1], 1'b0};
            wdata   = {2{rkd_q[15:0]}};
         end
         store_q[0]: begin
            we_mask = 4'b1111;
         end
         default: ;
      endcase
   end

   assign data_sram_en = es_valid_q && (is_load || is_store) && ms_allowin
                      && !es_ex && !ms_ex && !wb_ex;
   assign data_sram_we    = (data_sram_en && is_store) ? we_mask : 4'b0000;
   assign data_sram_addr  = {addr[31:2], 2'b00};
   assign data_sram_wdata = wdata;

   assign es_pc           = pc_q;
   assign es_alu_result   = alu_res;
   assign es_res_from_mem = is_load && !es_ex;
   assign es_rf_we        = rf_we_q && es_valid_q && !es_ex;
   assign es_rf_waddr     = waddr_q;
   assign es_ld_inst      = ld_q;
   assign es_csr_re       = csr_re_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         es_valid_q <= 1'b0;
         pc_q       <= '0;
         alu_op_q   <= '0;
         src1_q     <= '0;
         src2_q     <= '0;
         div_op_q   <= '0;
         ld_q       <= '0;
         store_q    <= '0;
         rkd_q      <= '0;
         rf_we_q    <= 1'b0;
         waddr_q    <= '0;
         csr_re_q   <= 1'b0;
         zip_q      <= '0;
         div_st_q   <= IDLE;
         rem_q      <= '0;
         quo_q      <= '0;
         dsor_q     <= '0;
         cnt_q      <= '0;
         qneg_q     <= 1'b0;
         rneg_q     <= 1'b0;
      end else begin
         es_valid_q <= es_valid_d;
         pc_q       <= pc_d;
         alu_op_q   <= alu_op_d;
         src1_q     <= src1_d;
         src2_q     <= src2_d;
         div_op_q   <= div_op_d;
         ld_q       <= ld_d;
         store_q    <= store_d;
         rkd_q      <= rkd_d;
         rf_we_q    <= rf_we_d;
         waddr_q    <= waddr_d;
         csr_re_q   <= csr_re_d;
         zip_q      <= zip_d;
         div_st_q   <= div_st_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         dsor_q     <= dsor_d;
         cnt_q      <= cnt_d;
         qneg_q     <= qneg_d;
         rneg_q     <= rneg_d;
      end
   end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: random + directed bench for ex_stage against a behavioural model.
// Ports: drives all ex_stage inputs, checks handoff payload and SRAM request.

module tb_ex_stage;
   logic        clk = 1'b0;
   logic        reset;
   logic        ds_to_es_valid;
   logic        es_allowin;
   logic [31:0] ds_pc;
   logic [11:0] ds_alu_op;
   logic [31:0] ds_alu_src1;
   logic [31:0] ds_alu_src2;
   logic [3:0]  ds_div_op;
   logic [4:0]  ds_ld_inst;
   logic [2:0]  ds_st_op;
   logic [31:0] ds_rkd_value;
   logic        ds_rf_we;
   logic [4:0]  ds_rf_waddr;
   logic        ds_csr_re;
   logic [85:0] ds_ex_zip;
   logic        ms_allowin;
   logic        ms_ex;
   logic        wb_ex;
   logic        es_to_ms_valid;
   logic [31:0] es_pc;
   logic [31:0] es_result;
   logic [31:0] es_alu_result;
   logic        es_res_from_mem;
   logic        es_rf_we;
   logic [4:0]  es_rf_waddr;
   logic [4:0]  es_ld_inst;
   logic        es_csr_re;
   logic [85:0] es_ex_zip;
   logic        data_sram_en;
   logic [3:0]  data_sram_we;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;

   int n_cmp = 0;
   int n_bad = 0;

   logic [11:0] t_aluop;
   logic [31:0] t_s1, t_s2, t_rkd, t_pc;
   logic [3:0]  t_div;
   logic [4:0]  t_ld;
   logic [2:0]  t_st;
   logic        t_we;
   logic [4:0]  t_wa;
   logic        t_csr;
   logic [85:0] t_zip;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk             (clk),
      .reset           (reset),
      .ds_to_es_valid  (ds_to_es_valid),
      .es_allowin      (es_allowin),
      .ds_pc           (ds_pc),
      .ds_alu_op       (ds_alu_op),
      .ds_alu_src1     (ds_alu_src1),
      .ds_alu_src2     (ds_alu_src2),
      .ds_div_op       (ds_div_op),
      .ds_ld_inst      (ds_ld_inst),
      .ds_st_op        (ds_st_op),
      .ds_rkd_value    (ds_rkd_value),
      .ds_rf_we        (ds_rf_we),
      .ds_rf_waddr     (ds_rf_waddr),
      .ds_csr_re       (ds_csr_re),
      .ds_ex_zip       (ds_ex_zip),
      .ms_allowin      (ms_allowin),
      .ms_ex           (ms_ex),
      .wb_ex           (wb_ex),
      .es_to_ms_valid  (es_to_ms_valid),
      .es_pc           (es_pc),
      .es_result       (es_result),
      .es_alu_result   (es_alu_result),
      .es_res_from_mem (es_res_from_mem),
      .es_rf_we        (es_rf_we),
      .es_rf_waddr     (es_rf_waddr),
      .es_ld_inst      (es_ld_inst),
      .es_csr_re       (es_csr_re),
      .es_ex_zip       (es_ex_zip),
      .data_sram_en    (data_sram_en),
      .data_sram_we    (data_sram_we),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata)
   );

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [11:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      logic [31:0] r;
      r = 0;
      for (int k = 0; k < 12; k++) begin
         if (op[k]) begin
            case (k)
               0:  r = a + b;
               1:  r = a - b;
               2:  r = ($signed(a) < $signed(b)) ? 1 : 0;
               3:  r = (a < b) ? 1 : 0;
               4:  r = a & b;
               5:  r = ~(a | b);
               6:  r = a | b;
               7:  r = a ^ b;
               8:  r = a << b[4:0];
               9:  r = a >> b[4:0];
               10: r = 32'($signed(a) >>> b[4:0]);
               default: r = b;
            endcase
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] ref_div(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic sgn,
                                           input logic want_q);
      logic na, nb;
      logic [31:0] ua, ub, q, r;
      if (b == 0) return want_q ? 32'hFFFF_FFFF : a;
      na = sgn && a[31];
      nb = sgn && b[31];
      ua = na ? -a : a;
      ub = nb ? -b : b;
      q = ua / ub;
      r = ua % ub;
      if (na != nb) q = -q;
      if (na) r = -r;
      return want_q ? q : r;
   endfunction

   task automatic set_nop();
      t_aluop = 12'h001;
      t_s1 = 0;
      t_s2 = 0;
      t_rkd = 0;
      t_pc = $urandom & 32'hFFFF_FFFC;
      t_div = 0;
      t_ld = 0;
      t_st = 0;
      t_we = 1'b1;
      t_wa = 5'($urandom_range(1, 31));
      t_csr = 1'b0;
      t_zip = 0;
   endtask

   task automatic issue();
      @(negedge clk);
      chk("allowin_pre", 128'(es_allowin), 128'(1));
      ds_pc = t_pc;
      ds_alu_op = t_aluop;
      ds_alu_src1 = t_s1;
      ds_alu_src2 = t_s2;
      ds_div_op = t_div;
      ds_ld_inst = t_ld;
      ds_st_op = t_st;
      ds_rkd_value = t_rkd;
      ds_rf_we = t_we;
      ds_rf_waddr = t_wa;
      ds_csr_re = t_csr;
      ds_ex_zip = t_zip;
      ds_to_es_valid = 1'b1;
      @(posedge clk);
      #1 ds_to_es_valid = 1'b0;
   endtask

   task automatic run_inst();
      logic [31:0] a, r, wd;
      logic [3:0] we, b1, b3;
      logic ale, ex, isdiv, lsany, en, seen, al2;
      int lat, exp_lat;
      b1 = 4'b0001;
      b3 = 4'b0011;
      a = ref_alu(t_aluop, t_s1, t_s2);
      ale = ((t_ld[2] | t_ld[1] | t_st[1]) && a[0])
         || ((t_ld[0] | t_st[0]) && a[1:0] != 0);
      ex = ale || (|t_zip[6:1]);
      isdiv = |t_div;
      r = a;
      if (t_div[3] | t_div[1]) r = ref_div(t_s1, t_s2, t_div[3], 1'b1);
      else if (t_div[2] | t_div[0]) r = ref_div(t_s1, t_s2, t_div[2], 1'b0);
      lsany = (|t_ld) || (|t_st);
      en = lsany && !ex && ms_allowin && !ms_ex;
      we = 0;
      wd = t_rkd;
      if (t_st[2]) begin
         we = b1 << a[1:0];
         wd = {4{t_rkd[7:0]}};
      end else if (t_st[1]) begin
         we = b3 << (2 * a[1]);
         wd = {2{t_rkd[15:0]}};
      end else if (t_st[0]) begin
         we = 4'hF;
      end
      if (!en) we = 0;
      exp_lat = (isdiv && !ex) ? 34 : 1;

      issue();
      lat = 0;
      seen = 1'b0;
      al2 = 1'b1;
      while (!seen && lat < 100) begin
         @(negedge clk);
         lat++;
         if (lat == 2) al2 = es_allowin;
         if (es_to_ms_valid) seen = 1'b1;
      end
      chk("latency", 128'(lat), 128'(exp_lat));
      if (isdiv && !ex) chk("div_stall_allowin", 128'(al2), 128'(0));
      chk("pc", 128'(es_pc), 128'(t_pc));
      if (!(isdiv && ex)) chk("result", 128'(es_result), 128'(r));
      chk("alu_result", 128'(es_alu_result), 128'(a));
      chk("rf_we", 128'(es_rf_we), 128'(t_we && !ex));
      chk("rf_waddr", 128'(es_rf_waddr), 128'(t_wa));
      chk("ld_inst", 128'(es_ld_inst), 128'(t_ld));
      chk("csr_re", 128'(es_csr_re), 128'(t_csr));
      chk("res_from_mem", 128'(es_res_from_mem), 128'((|t_ld) && !ex));
      chk("ex_zip", 128'(es_ex_zip), 128'({t_zip[85:1], ale}));
      chk("sram_en", 128'(data_sram_en), 128'(en));
      chk("sram_we", 128'(data_sram_we), 128'(we));
      chk("sram_addr", 128'(data_sram_addr), 128'({a[31:2], 2'b00}));
      if (|t_st) chk("sram_wdata", 128'(data_sram_wdata), 128'(wd));
      @(posedge clk);
      #1;
   endtask

   task automatic rand_inst();
      int kind, k;
      logic [95:0] z;
      set_nop();
      z = {$urandom, $urandom, $urandom};
      t_zip = z[85:0];
      t_zip[6:0] = 0;
      t_rkd = $urandom;
      t_we = 1'($urandom);
      t_csr = 1'($urandom);
      kind = $urandom_range(0, 9);
      if (kind == 9) begin
         t_zip[$urandom_range(1, 6)] = 1'b1;
         kind = $urandom_range(0, 8);
      end
      if (kind <= 4) begin
         t_aluop = 12'(1) << $urandom_range(0, 11);
         t_s1 = $urandom;
         t_s2 = $urandom;
      end else if (kind <= 6) begin
         t_div = 4'(1) << $urandom_range(0, 3);
         t_s1 = $urandom;
         k = $urandom_range(0, 4);
         if (k == 0) t_s2 = 0;
         else if (k == 1) t_s2 = 32'($signed($urandom_range(0, 16)) - 8);
         else t_s2 = $urandom;
      end else begin
         k = $urandom_range(0, 7);
         if (k < 5) t_ld = 5'(1) << k;
         else t_st = 3'(1) << (k - 5);
         t_s1 = $urandom & 32'hFFFF_FFF8;
         t_s2 = 32'($urandom_range(0, 7));
      end
   endtask

   initial begin
      reset = 1'b1;
      ds_to_es_valid = 1'b0;
      ds_pc = 0;
      ds_alu_op = 0;
      ds_alu_src1 = 0;
      ds_alu_src2 = 0;
      ds_div_op = 0;
      ds_ld_inst = 0;
      ds_st_op = 0;
      ds_rkd_value = 0;
      ds_rf_we = 0;
      ds_rf_waddr = 0;
      ds_csr_re = 0;
      ds_ex_zip = 0;
      ms_allowin = 1'b1;
      ms_ex = 1'b0;
      wb_ex = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_to_ms_valid", 128'(es_to_ms_valid), 128'(0));
      chk("rst_allowin", 128'(es_allowin), 128'(1));
      chk("rst_sram_en", 128'(data_sram_en), 128'(0));
      chk("rst_sram_we", 128'(data_sram_we), 128'(0));
      chk("rst_pc", 128'(es_pc), 128'(0));
      chk("rst_result", 128'(es_result), 128'(0));
      chk("rst_zip", 128'(es_ex_zip), 128'(0));
      chk("rst_rf_we", 128'(es_rf_we), 128'(0));

      set_nop(); t_s1 = 5; t_s2 = 7;
      run_inst();

      set_nop(); t_div = 4'b1000; t_s1 = -32'sd7; t_s2 = 2;
      run_inst();
      set_nop(); t_div = 4'b0100; t_s1 = -32'sd7; t_s2 = 2;
      run_inst();

      set_nop(); t_div = 4'b0010; t_s1 = 10; t_s2 = 0;
      run_inst();
      set_nop(); t_div = 4'b0001; t_s1 = 10; t_s2 = 0;
      run_inst();
      set_nop(); t_div = 4'b1000; t_s1 = -32'sd9; t_s2 = 0;
      run_inst();
      set_nop(); t_div = 4'b1000; t_s1 = 32'h8000_0000; t_s2 = 32'hFFFF_FFFF;
      run_inst();

      set_nop(); t_st = 3'b010; t_s1 = 32'h1000; t_s2 = 2; t_rkd = 32'hABCD;
      run_inst();
      set_nop(); t_st = 3'b010; t_s1 = 32'h1000; t_s2 = 1; t_rkd = 32'hABCD;
      run_inst();

      ms_ex = 1'b1;
      set_nop(); t_ld = 5'b00001; t_s1 = 32'h2000; t_s2 = 4;
      run_inst();
      ms_ex = 1'b0;

      ms_allowin = 1'b0;
      set_nop(); t_st = 3'b001; t_s1 = 32'h3000; t_s2 = 8; t_rkd = 32'h1234_5678;
      issue();
      @(negedge clk);
      chk("stall_en", 128'(data_sram_en), 128'(0));
      chk("stall_allowin", 128'(es_allowin), 128'(0));
      repeat (2) @(negedge clk);
      chk("stall_en_late", 128'(data_sram_en), 128'(0));
      ms_allowin = 1'b1;
      #1;
      chk("release_en", 128'(data_sram_en), 128'(1));
      chk("release_we", 128'(data_sram_we), 128'(4'hF));
      chk("release_addr", 128'(data_sram_addr), 128'(32'h3008));
      @(posedge clk);
      #1;

      set_nop(); t_div = 4'b1000; t_s1 = 100; t_s2 = 7;
      issue();
      repeat (12) @(negedge clk);
      wb_ex = 1'b1;
      @(negedge clk);
      wb_ex = 1'b0;
      #1;
      chk("flush_valid", 128'(es_to_ms_valid), 128'(0));
      chk("flush_allowin", 128'(es_allowin), 128'(1));
      set_nop(); t_div = 4'b0100; t_s1 = -32'sd100; t_s2 = 7;
      run_inst();

      for (int i = 0; i < 150; i++) begin
         rand_inst();
         run_inst();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
